// File: rtl/arith_pkg.sv
// Shared arithmetic-library types for the sequential multiplier.
// Holds the control FSM encoding and the counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Counter must reach WIDTH itself, so size it for WIDTH+1 values.
    function automatic int MULT_CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/add_n.sv
// Parametrised ripple-carry adder, generalising the 4-bit library adder.
// Port names follow the original adder so existing users map across directly.
module add_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIN,
    output logic [WIDTH-1:0] Y,
    output logic             CarryOUT
);

    always_comb begin
        logic carry;
        carry = CarryIN;
        Y     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            Y[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        CarryOUT = carry;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one partial product per clock.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port (two's complement).
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    input  logic               ack,
    output logic               ready,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] y
);

    localparam int CW = MULT_CNT_W(WIDTH);

    mult_state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               sign_in;

    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] y_next;
    logic               last;

`ifdef SEQ_MULT_SIGNED_EN
    assign a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
    assign sign_in = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign sign_in = 1'b0;
`endif

    add_n #(
        .WIDTH(WIDTH)
    ) u_add (
        .A       (acc[2*WIDTH-1:WIDTH]),
        .B       (mplier[0] ? mcand : '0),
        .CarryIN (1'b0),
        .Y       (sum),
        .CarryOUT(carry)
    );

    // Carry re-enters at the top as the whole pair shifts right.
    assign acc_shift = {carry, sum, acc[WIDTH-1:1]};
    assign y_next    = neg ? -acc : acc;
    assign last      = (cnt == CW'(WIDTH));

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    if (ack)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            y      <= '0;
        end else begin
            if (state == IDLE && start) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                acc    <= '0;
                cnt    <= '0;
                neg    <= sign_in;
            end else if (state == RUN) begin
                if (last) begin
                    y <= y_next;
                end else begin
                    acc    <= acc_shift;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against an arithmetic model.
// Covers latency, values, back-pressure, ignored start, reset mid-run.
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           sm_i = 1'b0;
    logic           ack = 1'b0;
    logic           ready;
    logic           busy;
    logic           valid;
    logic [2*W-1:0] y;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(sm_i),
`endif
        .ack        (ack),
        .ready      (ready),
        .busy       (busy),
        .valid      (valid),
        .y          (y)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                             input logic [W-1:0] z,
                                             input logic sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(z));
        else    p = longint'(x) * longint'(z);
        return p[2*W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] z,
                         input logic sm);
        start = 1'b1;
        a_i   = x;
        b_i   = z;
        sm_i  = sm;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output logic [2*W-1:0] res);
        lat = 0;
        while (!valid && lat < 100) begin
            step();
            lat++;
        end
        res = y;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if ({ready, busy, valid} !== 3'b100 || y !== '0) begin
            bad++;
            $display("FAIL reset: rdy/busy/vld=%b y=%h want 100 y=0",
                     {ready, busy, valid}, y);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_timing();
        int lat;
        logic [2*W-1:0] res;
        issue(8'd15, 8'd15, 1'b0);
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL accept: busy=%b ready=%b want 1 0", busy, ready);
        end
        wait_valid(lat, res);
        total++;
        if (lat != W + 1) begin
            bad++;
            $display("FAIL latency: got %0d want %0d", lat, W + 1);
        end
        total++;
        if (res !== 16'd225) begin
            bad++;
            $display("FAIL timing_y: got %h want %h", res, 16'd225);
        end
        do_ack();
        total++;
        if (ready !== 1'b1 || valid !== 1'b0 || y !== 16'd225) begin
            bad++;
            $display("FAIL post_ack: ready=%b valid=%b y=%h want 1 0 00e1",
                     ready, valid, y);
        end
    endtask

    task automatic test_values();
        logic [W-1:0] ta [$];
        logic [W-1:0] tb [$];
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        ta = '{8'd0, 8'd13, 8'd255, 8'd1, 8'd128};
        tb = '{8'd200, 8'd11, 8'd255, 8'd0, 8'd2};
        for (int i = 0; i < 10; i++) begin
            ta.push_back(W'($urandom));
            tb.push_back(W'($urandom));
        end
        for (int i = 0; i < ta.size(); i++) begin
            exp = model(ta[i], tb[i], 1'b0);
            issue(ta[i], tb[i], 1'b0);
            wait_valid(lat, res);
            total++;
            if (res !== exp || lat != W + 1) begin
                bad++;
                $display("FAIL value %0d*%0d: got %h lat %0d want %h lat %0d",
                         ta[i], tb[i], res, lat, exp, W + 1);
            end
            do_ack();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        logic [W-1:0] x;
        logic [W-1:0] z;
        x = W'($urandom);
        z = W'($urandom);
        exp = model(x, z, 1'b0);
        issue(x, z, 1'b0);
        wait_valid(lat, res);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            a_i   = W'($urandom);
            b_i   = W'($urandom);
            step();
            total++;
            if (valid !== 1'b1 || y !== exp) begin
                bad++;
                $display("FAIL hold cyc %0d: valid=%b y=%h want 1 %h",
                         i, valid, y, exp);
            end
        end
        start = 1'b0;
        do_ack();
        total++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_ack: ready=%b valid=%b want 1 0", ready, valid);
        end
        step();
        total++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_queue: busy=%b ready=%b want 0 1", busy, ready);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        int seen;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        exp = model(8'd77, 8'd91, 1'b0);
        issue(8'd77, 8'd91, 1'b0);
        step();
        issue(8'd3, 8'd5, 1'b0);
        wait_valid(lat, res);
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL ign_start: got %h want %h", res, exp);
        end
        do_ack();
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (valid || busy) seen++;
            step();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL ign_second: busy/valid cycles %0d want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        issue(8'd201, 8'd99, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, busy, valid} !== 3'b100 || y !== '0) begin
            bad++;
            $display("FAIL mid_reset: rdy/busy/vld=%b y=%h want 100 y=0",
                     {ready, busy, valid}, y);
        end
        step();
        rst_n = 1'b1;
        step();
        exp = model(8'd37, 8'd222, 1'b0);
        issue(8'd37, 8'd222, 1'b0);
        wait_valid(lat, res);
        total++;
        if (res !== exp || lat != W + 1) begin
            bad++;
            $display("FAIL after_reset: got %h lat %0d want %h lat %0d",
                     res, lat, exp, W + 1);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] z;
            x = W'($urandom);
            z = W'($urandom);
            exp = model(x, z, 1'b0);
            issue(x, z, 1'b0);
            wait_valid(lat, res);
            total++;
            if (res !== exp) begin
                bad++;
                $display("FAIL b2b %0d: got %h want %h", i, res, exp);
            end
            do_ack();
        end
    endtask

`ifdef SEQ_MULT_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] ta [$];
        logic [W-1:0] tb [$];
        logic         sm [$];
        int lat;
        logic [2*W-1:0] res;
        logic [2*W-1:0] exp;
        ta = '{8'hFD, 8'h80, 8'h7F, 8'hFF};
        tb = '{8'h05, 8'h80, 8'h81, 8'hFF};
        sm = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            ta.push_back(W'($urandom));
            tb.push_back(W'($urandom));
            sm.push_back(1'($urandom));
        end
        for (int i = 0; i < ta.size(); i++) begin
            exp = model(ta[i], tb[i], sm[i]);
            issue(ta[i], tb[i], sm[i]);
            wait_valid(lat, res);
            total++;
            if (res !== exp || lat != W + 1) begin
                bad++;
                $display("FAIL signed %h*%h sm=%b: got %h want %h",
                         ta[i], tb[i], sm[i], res, exp);
            end
            do_ack();
        end
        sm_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_values();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
